turn_request_buffer: RTL

Converts raw controller button vectors into debounced, edge-detected turn commands for `game_controller`. It sits between the controller readers (NES or bongo button vector, selected upstream) and the game logic. It holds each turn request as a pending command until the game consumes it or a timeout expires, so a short tap between game ticks is never lost. It also produces a single-cycle start strobe.

---
 rtl/pacman_pkg.sv | 55 +++++
 rtl/btn_debounce.sv | 46 ++++
 rtl/turn_request_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man control definitions: directions, turn codes, button bits
// and direction helpers used by the turn buffer and the game controller.
package pacman_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RT = 2'b00;
  localparam dir_t DIR_UP = 2'b01;
  localparam dir_t DIR_DN = 2'b10;
  localparam dir_t DIR_LT = 2'b11;

  typedef enum logic [1:0] {
    TURN_NONE = 2'b00,
    TURN_L    = 2'b01,
    TURN_R    = 2'b10,
    TURN_U    = 2'b11
  } turn_t;

  localparam int NUM_BTNS   = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Direction reached by turning left from facing f.
  function automatic dir_t left_of(input dir_t f);
    dir_t r;
    case (f)
      DIR_RT:  r = DIR_UP;
      DIR_UP:  r = DIR_LT;
      DIR_LT:  r = DIR_DN;
      default: r = DIR_RT;
    endcase
    return r;
  endfunction

  // The encoding puts opposite directions at bitwise complements.
  function automatic dir_t opposite(input dir_t f);
    return ~f;
  endfunction

  function automatic turn_t dir_to_turn(input dir_t d, input dir_t f);
    turn_t t;
    if (d == f)                t = TURN_NONE;
    else if (d == opposite(f)) t = TURN_U;
    else if (d == left_of(f))  t = TURN_L;
    else                       t = TURN_R;
    return t;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-bit tick-sampled debouncer. rise is combinational so the consumer can
// register the command on the same edge that flips the debounced state.
module btn_debounce #(
  parameter int W        = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] state,
  output logic [W-1:0] rise
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [3:0] cnt_q;
    logic       state_q;
    logic       differs;
    logic       flip;

    assign differs = raw[i] != state_q;
    assign flip    = tick && differs && ((cnt_q + 4'd1) == DB);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
      end else if (tick) begin
        if (flip) begin
          state_q <= ~state_q;
          cnt_q   <= '0;
        end else if (differs) begin
          cnt_q   <= cnt_q + 4'd1;
        end else begin
          cnt_q   <= '0;
        end
      end
    end

    assign state[i] = state_q;
    assign rise[i]  = flip & ~state_q;
  end

endmodule

// File: rtl/turn_request_buffer.sv
// Turns debounced button rises into a held turn request for the game logic,
// plus a one-cycle start strobe.
module turn_request_buffer
  import pacman_pkg::*;
#(
  parameter int DEBOUNCE   = 2,
  parameter int HOLD_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ctrl_mode,
  input  logic [1:0] pacman_dir,
  input  logic [7:0] btns,
  input  logic       turn_ack,
  output logic       turn_valid,
  output logic [1:0] turn_cmd,
  output logic       start_pulse
);

  localparam logic [7:0] HOLD = 8'(HOLD_TICKS);

  logic [NUM_BTNS-1:0] db_state;
  logic [NUM_BTNS-1:0] rise;
  logic [7:0]          hold_q;
  turn_t               new_cmd;
  dir_t                dpad_dir;
  logic                dpad_hit;

  btn_debounce #(.W(NUM_BTNS), .DEBOUNCE(DEBOUNCE)) u_db (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (btns),
    .state (db_state),
    .rise  (rise)
  );

  // Levels and the select rise are not consumed by this block.
  logic unused_bits;
  assign unused_bits = ^{db_state, rise[BTN_SELECT]};

  always_comb begin
    new_cmd  = TURN_NONE;
    dpad_dir = DIR_RT;
    dpad_hit = 1'b0;
    if (!ctrl_mode) begin
      if (rise[BTN_B])         new_cmd = TURN_L;
      else if (rise[BTN_A])    new_cmd = TURN_R;
      else if (rise[BTN_DOWN]) new_cmd = TURN_U;
    end else begin
      dpad_hit = 1'b1;
      if (rise[BTN_UP])         dpad_dir = DIR_UP;
      else if (rise[BTN_DOWN])  dpad_dir = DIR_DN;
      else if (rise[BTN_LEFT])  dpad_dir = DIR_LT;
      else if (rise[BTN_RIGHT]) dpad_dir = DIR_RT;
      else                      dpad_hit = 1'b0;
      if (dpad_hit) new_cmd = dir_to_turn(dpad_dir, pacman_dir);
    end
  end

  // New command beats ack; ack beats the hold countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      turn_valid  <= 1'b0;
      turn_cmd    <= TURN_NONE;
      hold_q      <= '0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= rise[BTN_START];
      if (new_cmd != TURN_NONE) begin
        turn_valid <= 1'b1;
        turn_cmd   <= new_cmd;
        hold_q     <= HOLD;
      end else if (turn_ack && turn_valid) begin
        turn_valid <= 1'b0;
        turn_cmd   <= TURN_NONE;
        hold_q     <= '0;
      end else if (tick && turn_valid) begin
        hold_q <= hold_q - 8'd1;
        if (hold_q == 8'd1) begin
          turn_valid <= 1'b0;
          turn_cmd   <= TURN_NONE;
        end
      end
    end
  end

endmodule
